// File: rtl/shared_mult_sched.sv
// Round-robin scheduler sharing one pipelined signed multiplier between NREQ lanes.
// Define SHARED_MULT_SCHED_STATS_EN to add saturating grant/stall/idle counters.
module shared_mult_sched #(
    parameter int NREQ     = 4,
    parameter int BITS     = 17,
    parameter int WBITS    = 18,
    parameter int MULT_LAT = 2,
    parameter int IDW      = $clog2(NREQ),
    parameter int PW       = BITS + WBITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*BITS-1:0]   req_data,
    input  logic [NREQ*WBITS-1:0]  req_weight,
    output logic [BITS-1:0]        mult_a,
    output logic [WBITS-1:0]       mult_b,
    output logic                   mult_ce,
    input  logic [PW-1:0]          mult_p,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [PW-1:0]          rsp_data,
    output logic [IDW-1:0]         rsp_id
`ifdef SHARED_MULT_SCHED_STATS_EN
    ,
    output logic [NREQ*16-1:0]     stat_grants,
    output logic [15:0]            stat_stall,
    output logic [15:0]            stat_idle
`endif
);

    logic                stall;
    logic                accept;
    logic                grant_found;
    logic [IDW-1:0]      grant_idx;
    logic [IDW:0]        cand;

    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [BITS-1:0]     a_q, a_d;
    logic [WBITS-1:0]    b_q, b_d;
    logic                issue_v_q, issue_v_d;
    logic [IDW-1:0]      issue_tag_q, issue_tag_d;
    logic [MULT_LAT-1:0] tag_v_q, tag_v_d;
    logic [IDW-1:0]      tag_id_q [MULT_LAT];
    logic [IDW-1:0]      tag_id_d [MULT_LAT];

    // A held response freezes the whole pipe, multiplier included.
    assign stall   = rsp_valid & ~rsp_ready;
    assign mult_ce = ~stall;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    assign accept = grant_found & ~stall & ~reset;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        issue_v_d   = issue_v_q;
        issue_tag_d = issue_tag_q;
        if (!stall) begin
            issue_v_d = accept;
            if (accept) begin
                a_d         = req_data[grant_idx*BITS +: BITS];
                b_d         = req_weight[grant_idx*WBITS +: WBITS];
                issue_tag_d = grant_idx;
                ptr_d       = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Tag stages track the multiplier's register stages one for one.
    always_comb begin
        tag_v_d  = tag_v_q;
        tag_id_d = tag_id_q;
        if (!stall) begin
            tag_v_d[0]  = issue_v_q;
            tag_id_d[0] = issue_tag_q;
            for (int i = 1; i < MULT_LAT; i++) begin
                tag_v_d[i]  = tag_v_q[i-1];
                tag_id_d[i] = tag_id_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            issue_v_q   <= 1'b0;
            issue_tag_q <= '0;
            tag_v_q     <= '0;
            for (int i = 0; i < MULT_LAT; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            issue_v_q   <= issue_v_d;
            issue_tag_q <= issue_tag_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
        end
    end

    assign mult_a    = a_q;
    assign mult_b    = b_q;
    assign rsp_valid = tag_v_q[MULT_LAT-1];
    assign rsp_id    = tag_id_q[MULT_LAT-1];
    assign rsp_data  = mult_p;

`ifdef SHARED_MULT_SCHED_STATS_EN
    logic [15:0] grant_cnt_q [NREQ];
    logic [15:0] grant_cnt_d [NREQ];
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        if (accept && grant_cnt_q[grant_idx] != 16'hFFFF) begin
            grant_cnt_d[grant_idx] = grant_cnt_q[grant_idx] + 16'd1;
        end
        if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (!stall && !accept && idle_cnt_q != 16'hFFFF) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NREQ; i++) begin
            stat_grants[i*16 +: 16] = grant_cnt_q[i];
        end
    end

    assign stat_stall = stall_cnt_q;
    assign stat_idle  = idle_cnt_q;
`endif

endmodule

// File: tb/tb_shared_mult_sched.sv
// Directed bench for shared_mult_sched with a behavioural two-stage signed multiplier.
module tb_shared_mult_sched;
    localparam int NREQ  = 4;
    localparam int BITS  = 17;
    localparam int WBITS = 18;
    localparam int PW    = BITS + WBITS;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*BITS-1:0]  req_data = '0;
    logic [NREQ*WBITS-1:0] req_weight = '0;
    logic [BITS-1:0]       mult_a;
    logic [WBITS-1:0]      mult_b;
    logic                  mult_ce;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [PW-1:0]         rsp_data;
    logic [IDW-1:0]        rsp_id;
`ifdef SHARED_MULT_SCHED_STATS_EN
    logic [NREQ*16-1:0]    stat_grants;
    logic [15:0]           stat_stall;
    logic [15:0]           stat_idle;
`endif

    logic signed [BITS-1:0]  mul_a_r = '0;
    logic signed [WBITS-1:0] mul_b_r = '0;
    logic signed [PW-1:0]    mul_p_r = '0;

    int errors = 0;
    int checks = 0;
    int hs_count;
    logic signed [PW-1:0] prod_tab [4];
    int v_tab   [14] = '{15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 0, 0, 0, 0};
    int rdy_tab [14] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    int rr_tab  [14] = '{1, 2, 4, 0, 0, 0, 0, 8, 1, 2, 0, 0, 0, 0};
    int ce_tab  [14] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    int rv_tab  [14] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int id_tab  [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 1, 0};
    int order3  [6]  = '{0, 1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    // Stand-in for mult_op: registered operands then registered product, both clock-enabled.
    always @(posedge clk) begin
        if (mult_ce) begin
            mul_a_r <= mult_a;
            mul_b_r <= mult_b;
            mul_p_r <= PW'(mul_a_r) * PW'(mul_b_r);
        end
    end

    shared_mult_sched dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_weight (req_weight),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_ce    (mult_ce),
        .mult_p     (mul_p_r),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
`ifdef SHARED_MULT_SCHED_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_stall (stat_stall),
        .stat_idle  (stat_idle)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic rr);
        req_valid = v;
        rsp_ready = rr;
        #1;
    endtask

    task automatic setLane(input int lane, input int d, input int w);
        req_data[lane*BITS +: BITS]    = BITS'(d);
        req_weight[lane*WBITS +: WBITS] = WBITS'(w);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkData(input string tag, input logic signed [PW-1:0] obs,
                             input logic signed [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        tick();
        reset = 1'b1;
        applyStimulus('0, 1'b1);
        tick();
        reset = 1'b0;
        applyStimulus('0, 1'b1);
    endtask

    initial begin
        prod_tab[0] = 35'sd21;
        prod_tab[1] = -35'sd108;
        prod_tab[2] = -35'sd1000000;
        prod_tab[3] = 35'sd56;

        // Reset values
        applyStimulus('0, 1'b1);
        tick();
        tick();
        checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_rsp_id", 32'(rsp_id), 32'h0);
        checkOutput("rst_mult_a", 32'(mult_a), 32'h0);
        checkOutput("rst_mult_b", 32'(mult_b), 32'h0);
        checkOutput("rst_mult_ce", 32'(mult_ce), 32'h1);
        tick();
        reset = 1'b0;
        applyStimulus('0, 1'b1);

        // Single request on lane 2: 5 * -5
        tick();
        setLane(2, 5, -5);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("t1_grant", 32'(req_ready), 32'h4);
        tick();
        applyStimulus('0, 1'b1);
        checkOutput("t1_mult_a", 32'(mult_a), 32'h5);
        checkOutput("t1_mult_b", 32'(mult_b), 32'h3FFFB);
        checkOutput("t1_rv_c1", 32'(rsp_valid), 32'h0);
        tick();
        checkOutput("t1_rv_c2", 32'(rsp_valid), 32'h0);
        tick();
        checkOutput("t1_rv_c3", 32'(rsp_valid), 32'h1);
        checkOutput("t1_id_c3", 32'(rsp_id), 32'h2);
        checkData("t1_data_c3", rsp_data, -35'sd25);
        tick();
        checkOutput("t1_rv_c4", 32'(rsp_valid), 32'h0);

        // All lanes valid for 8 cycles: rotation and in-order responses
        doReset();
        setLane(0, 3, 7);
        setLane(1, -12, 9);
        setLane(2, 1000, -1000);
        setLane(3, -7, -8);
        for (int c = 0; c < 12; c++) begin
            tick();
            applyStimulus((c < 8) ? 4'hF : 4'h0, 1'b1);
            checkOutput($sformatf("t2_grant_c%0d", c), 32'(req_ready),
                        (c < 8) ? (32'h1 << (c % 4)) : 32'h0);
            if (c >= 3 && c < 11) begin
                checkOutput($sformatf("t2_rv_c%0d", c), 32'(rsp_valid), 32'h1);
                checkOutput($sformatf("t2_id_c%0d", c), 32'(rsp_id), 32'((c - 3) % 4));
                checkData($sformatf("t2_data_c%0d", c), rsp_data, prod_tab[(c - 3) % 4]);
            end else begin
                checkOutput($sformatf("t2_rv_c%0d", c), 32'(rsp_valid), 32'h0);
            end
        end

        // Backpressure: six accepts, consumer stalls four cycles at the first response
        hs_count = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            applyStimulus(4'(v_tab[c]), 1'(rdy_tab[c]));
            checkOutput($sformatf("t3_grant_c%0d", c), 32'(req_ready), 32'(rr_tab[c]));
            checkOutput($sformatf("t3_ce_c%0d", c), 32'(mult_ce), 32'(ce_tab[c]));
            checkOutput($sformatf("t3_rv_c%0d", c), 32'(rsp_valid), 32'(rv_tab[c]));
            if (rv_tab[c] == 1) begin
                checkOutput($sformatf("t3_id_c%0d", c), 32'(rsp_id), 32'(id_tab[c]));
                checkData($sformatf("t3_data_c%0d", c), rsp_data, prod_tab[id_tab[c]]);
            end
            if (rsp_valid && rsp_ready) begin
                if (hs_count < 6) begin
                    checkOutput($sformatf("t3_order_%0d", hs_count), 32'(rsp_id),
                                32'(order3[hs_count]));
                end
                hs_count++;
            end
        end
        checkOutput("t3_delivered", 32'(hs_count), 32'd6);

        // Extreme operands; pointer sits at lane 2 here
        tick();
        setLane(2, -65536, -131072);
        setLane(3, 65535, 131071);
        applyStimulus(4'b1100, 1'b1);
        checkOutput("t4_grant0", 32'(req_ready), 32'h4);
        tick();
        applyStimulus(4'b1000, 1'b1);
        checkOutput("t4_grant1", 32'(req_ready), 32'h8);
        checkOutput("t4_mult_a", 32'(mult_a), 32'h10000);
        checkOutput("t4_mult_b", 32'(mult_b), 32'h20000);
        tick();
        applyStimulus('0, 1'b1);
        checkOutput("t4_rv_c2", 32'(rsp_valid), 32'h0);
        tick();
        checkOutput("t4_id_min", 32'(rsp_id), 32'h2);
        checkData("t4_data_min", rsp_data, 35'sd8589934592);
        tick();
        checkOutput("t4_id_max", 32'(rsp_id), 32'h3);
        checkData("t4_data_max", rsp_data, 35'sd8589737985);
        tick();
        checkOutput("t4_rv_c5", 32'(rsp_valid), 32'h0);

        // Reset with two products in flight; pointer would otherwise be at lane 3
        tick();
        setLane(1, 2, 3);
        setLane(2, 4, 5);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("t5_grant_l1", 32'(req_ready), 32'h2);
        tick();
        applyStimulus(4'b0100, 1'b1);
        checkOutput("t5_grant_l2", 32'(req_ready), 32'h4);
        tick();
        reset = 1'b1;
        applyStimulus('0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            tick();
            reset = 1'b0;
            applyStimulus('0, 1'b1);
            checkOutput($sformatf("t5_flush_c%0d", c), 32'(rsp_valid), 32'h0);
        end
        tick();
        setLane(0, 3, 7);
        setLane(3, -7, -8);
        applyStimulus(4'b1001, 1'b1);
        checkOutput("t5_grant_after_rst", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(4'b1000, 1'b1);
        checkOutput("t5_grant_l3", 32'(req_ready), 32'h8);
        tick();
        applyStimulus('0, 1'b1);
        tick();
        checkOutput("t5_id_a", 32'(rsp_id), 32'h0);
        checkData("t5_data_a", rsp_data, 35'sd21);
        tick();
        checkOutput("t5_id_b", 32'(rsp_id), 32'h3);
        checkData("t5_data_b", rsp_data, 35'sd56);
        tick();
        checkOutput("t5_rv_end", 32'(rsp_valid), 32'h0);

`ifdef SHARED_MULT_SCHED_STATS_EN
        // Ten accepts on lane 1, then three stall cycles while responses are pending
        doReset();
        setLane(1, 1, 1);
        for (int c = 0; c < 10; c++) begin
            tick();
            applyStimulus(4'b0010, 1'b1);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            applyStimulus('0, 1'b0);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            applyStimulus('0, 1'b1);
        end
        checkOutput("st_grants_l1", 32'(stat_grants[16 +: 16]), 32'd10);
        checkOutput("st_grants_l0", 32'(stat_grants[0 +: 16]), 32'd0);
        checkOutput("st_stall", 32'(stat_stall), 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
